inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the 64-bit MIPS CPU, sitting directly upstream of `control_unit`. It owns the program counter and fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake. It holds each word in an instruction register, presenting the opcode to `control_unit` and the full word to the datapath. On each `PCen` from the control unit it advances to PC+4, the branch target (`PCSrc`), or the jump target.

## Interface
- `ADDR_W`, 64: PC and memory address width.
- `RESET_PC`, 64'h0: PC value loaded on reset; must be word-aligned.
- `TIMEOUT`, 255: maximum FETCH cycles before error; used only with `IFETCH_TIMEOUT_EN`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCen`  in  1  from `control_unit`: retire the current instruction and update the PC.
- `PCSrc`  in  1  from `control_unit`: take the branch target.
- `jump`  in  1  J-type: take the jump target; has priority over `PCSrc`.
- `branch_off`  in  16  branch immediate, treated as signed.
- `jump_idx`  in  26  J-type index field.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address; equals `pc_out` while `imem_req` is high.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `ir_out`  out  32  instruction register.
- `opcode`  out  6  `ir_out[31:26]`, feeds `control_unit`.
- `ir_valid`  out  1  `ir_out` holds a valid instruction.
- `pc_out`  out  ADDR_W  address of the instruction in `ir_out`, or of the one being fetched.
- `fetch_err`  out  1  sticky fetch timeout flag; tied to 0 without `IFETCH_TIMEOUT_EN`.

## Operation
- **Reset values:** state IDLE; `pc_out` = `imem_addr` = `RESET_PC`; `imem_req` = 0; `ir_out` = 0; `opcode` = 0; `ir_valid` = 0; `fetch_err` = 0.
- **States:** IDLE, FETCH, DECODE, ERR (ERR exists only with the macro).
- **IDLE -> FETCH:** on the first rising edge after `rst_n` deasserts.
- **FETCH:**
  - `imem_req` = 1 and `imem_addr` = `pc_out`, both held stable until `imem_ack`.
  - On the `imem_ack` edge: `ir_out` <= `imem_rdata`, `ir_valid` <= 1, go to DECODE.
  - `PCen`, `PCSrc` and `jump` are ignored in FETCH.
- **DECODE:**
  - `imem_req` = 0; `ir_out` is held.
  - On an edge with `PCen` = 1: `pc_out` <= next PC, `ir_valid` <= 0, go to FETCH.
- **Next PC** (pc4 = `pc_out` + 4, computed modulo 2^ADDR_W):
  - `jump` = 1: {pc4[ADDR_W-1:28], `jump_idx`, 2'b00}.
  - else `PCSrc` = 1: pc4 + (sign-extended `branch_off` << 2).
  - else: pc4.
- **Boundary rules:**
  - `jump` and `PCSrc` both high: the jump is taken.
  - A negative offset wraps modulo 2^ADDR_W.
  - pc4 overflow at the top of the address space wraps to 0.
  - Reset mid-FETCH drops `imem_req` immediately (asynchronously); a late `imem_ack` after reset is ignored.
  - `imem_ack` outside FETCH is ignored.

## Timing
- `imem_ack` may arrive in the first FETCH cycle (zero-wait memory); the FSM enters DECODE on the next edge.
- Minimum throughput: 2 cycles per instruction (1 FETCH + 1 DECODE with `PCen` = 1).
- `opcode` and `ir_out` change only on the edge that captures `imem_rdata`, and are stable throughout DECODE.
- `pc_out` changes only on the DECODE->FETCH edge. The new address appears on `imem_addr` in the first FETCH cycle.
- Latency from `imem_ack` to `ir_valid` is 1 cycle (registered).

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to FETCH and increments every FETCH cycle without `imem_ack`.
  - When the counter reaches `TIMEOUT`: `fetch_err` <= 1, `imem_req` <= 0, go to ERR.
  - ERR is terminal until `rst_n` is asserted.
- `IFETCH_TIMEOUT_EN` undefined: no counter, no ERR state, `fetch_err` is constant 0, and FETCH waits indefinitely.

## Test plan
- Reset, then zero-wait `imem_ack`, `imem_rdata` = 32'h2008_0005 -> `imem_addr` = 0 in cycle 1; `opcode` = 6'b001000, `ir_valid` = 1 in cycle 2.
- `pc_out` = 0x100, `PCen` = 1, `PCSrc` = 1, `branch_off` = 16'hFFFE -> next `imem_addr` = 0x0FC.
- `pc_out` = 0x1000_0000, `jump` = 1, `PCSrc` = 1, `jump_idx` = 26'h40 -> next `imem_addr` = 0x1000_0100 (jump wins).
- `imem_ack` delayed 5 cycles -> `imem_req` and `imem_addr` stable for 6 cycles; `ir_valid` = 0 until the cycle after `imem_ack`.
- `rst_n` pulsed low mid-FETCH, with `imem_ack` arriving 1 cycle after release -> `imem_req` = 0 during reset, PC = `RESET_PC`, and the stray ack is not captured unless the FSM is already in FETCH.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT` = 4, no `imem_ack` -> `fetch_err` = 1 after 4 FETCH cycles, `imem_req` = 0, and `fetch_err` stays 1 until reset.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS64 fetch stage owning the PC and instruction register, fetching over a req/ack handshake.
// Optional fetch timeout with a sticky error state when IFETCH_TIMEOUT_EN is defined.
module inst_fetch #(
   parameter int ADDR_W = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef IFETCH_TIMEOUT_EN
   , parameter int TIMEOUT = 255
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              PCen,
   input  logic              PCSrc,
   input  logic              jump,
   input  logic [15:0]       branch_off,
   input  logic [25:0]       jump_idx,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       ir_out,
   output logic [5:0]        opcode,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              fetch_err
);
   typedef enum logic [1:0] {IDLE, FETCH, DECODE, ERR} state_t;
   state_t state;
   logic [ADDR_W-1:0] pc4, bra, jmp, next_pc;
   assign pc4 = pc_out + ADDR_W'(4);
   assign bra = pc4 + {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};
   assign jmp = {pc4[ADDR_W-1:28], jump_idx, 2'b00};
   assign next_pc = jump ? jmp : PCSrc ? bra : pc4;
   assign imem_addr = pc_out;
   assign opcode = ir_out[31:26];
`ifdef IFETCH_TIMEOUT_EN
   logic [15:0] cnt;
`else
   assign fetch_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc_out <= RESET_PC;
         imem_req <= 1'b0;
         ir_out <= '0;
         ir_valid <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         cnt <= '0;
         fetch_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               imem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
               cnt <= '0;
`endif
            end
            FETCH: begin
               if (imem_ack) begin
                  ir_out <= imem_rdata;
                  ir_valid <= 1'b1;
                  imem_req <= 1'b0;
                  state <= DECODE;
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (cnt == 16'(TIMEOUT - 1)) begin
                  fetch_err <= 1'b1;
                  imem_req <= 1'b0;
                  state <= ERR;
               end else
                  cnt <= cnt + 16'd1;
`endif
            end
            DECODE: begin
               if (PCen) begin
                  pc_out <= next_pc;
                  ir_valid <= 1'b0;
                  imem_req <= 1'b1;
                  state <= FETCH;
`ifdef IFETCH_TIMEOUT_EN
                  cnt <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven next-PC vectors plus handshake/reset corner sequences, scoreboarded fetches.
module tb_inst_fetch;
   logic clk = 1'b0, rst_n = 1'b0, PCen = 1'b0, PCSrc = 1'b0, jump = 1'b0, imem_ack = 1'b0;
   logic [15:0] branch_off = '0;
   logic [25:0] jump_idx = '0;
   logic [31:0] imem_rdata = '0;
   logic imem_req, ir_valid, fetch_err;
   logic [63:0] imem_addr, pc_out;
   logic [31:0] ir_out;
   logic [5:0] opcode;
   int passed = 0, total = 0;
   logic [63:0] addr_q[$];
   logic [31:0] ir_q[$];
   logic req_q = 1'b0, val_q = 1'b0;
   typedef struct {
      logic pcsrc;
      logic jmp;
      logic [15:0] off;
      logic [25:0] idx;
      logic [31:0] word;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[11];
   vec_t tmp;

   always #5 clk = ~clk;

   inst_fetch #(
      .ADDR_W(64), .RESET_PC(64'h0)
`ifdef IFETCH_TIMEOUT_EN
      , .TIMEOUT(4)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .PCen(PCen), .PCSrc(PCSrc), .jump(jump),
      .branch_off(branch_off), .jump_idx(jump_idx), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_out(ir_out), .opcode(opcode), .ir_valid(ir_valid), .pc_out(pc_out),
      .fetch_err(fetch_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Sample at the falling edge; a rising imem_req or ir_valid consumes a scoreboard entry.
   task automatic tick();
      @(negedge clk);
      if (imem_req && !req_q) begin
         if (addr_q.size() == 0) begin
            total++;
            $display("FAIL fetch_pending: fetch of %h started with nothing expected", imem_addr);
         end else check("fetch_addr", imem_addr, addr_q.pop_front());
      end
      if (ir_valid && !val_q) begin
         if (ir_q.size() == 0) begin
            total++;
            $display("FAIL ir_pending: ir_out %h valid with nothing expected", ir_out);
         end else begin
            logic [31:0] w;
            w = ir_q.pop_front();
            check("ir_out", ir_out, w);
            check("opcode", opcode, w[31:26]);
         end
      end
      req_q = imem_req;
      val_q = ir_valid;
   endtask

   task automatic fetch(input logic [31:0] word, input int waits);
      int n;
      logic [63:0] a;
      n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      if (!imem_req) begin
         total++;
         $display("FAIL fetch_wait: imem_req got %b required 1 within 20 cycles", imem_req);
         return;
      end
      a = imem_addr;
      for (int i = 0; i < waits; i++) begin
         tick();
         check("req_hold", imem_req, 1);
         check("addr_hold", imem_addr, a);
         check("valid_low", ir_valid, 0);
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      ir_q.push_back(word);
      tick();
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      check("ir_valid_set", ir_valid, 1);
      check("req_drop", imem_req, 0);
   endtask

   task automatic retire(input vec_t v);
      PCen = 1'b1;
      PCSrc = v.pcsrc;
      jump = v.jmp;
      branch_off = v.off;
      jump_idx = v.idx;
      addr_q.push_back(v.exp);
      tick();
      PCen = 1'b0;
      PCSrc = 1'b0;
      jump = 1'b0;
      check("pc_out", pc_out, v.exp);
      check("valid_clr", ir_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 16'h0000, 26'h0000040, 32'h8C22_0010, 64'h0000_0000_0000_0100};
      vecs[1]  = '{1'b1, 1'b0, 16'hFFFE, 26'h0000000, 32'h1000_FFFE, 64'h0000_0000_0000_00FC};
      vecs[2]  = '{1'b0, 1'b1, 16'h0000, 26'h3FFFFFF, 32'h0BFF_FFFF, 64'h0000_0000_0FFF_FFFC};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0020, 64'h0000_0000_1000_0000};
      vecs[4]  = '{1'b1, 1'b1, 16'h7FFF, 26'h0000040, 32'h0800_0040, 64'h0000_0000_1000_0100};
      vecs[5]  = '{1'b1, 1'b0, 16'h0010, 26'h0000000, 32'h1440_0010, 64'h0000_0000_1000_0144};
      vecs[6]  = '{1'b0, 1'b1, 16'h0000, 26'h0000000, 32'hAC01_0000, 64'h0000_0000_1000_0000};
      vecs[7]  = '{1'b1, 1'b0, 16'h8000, 26'h0000000, 32'h3C01_1234, 64'h0000_0000_0FFE_0004};
      vecs[8]  = '{1'b0, 1'b1, 16'h0000, 26'h0000000, 32'h2408_0001, 64'h0000_0000_0000_0000};
      vecs[9]  = '{1'b1, 1'b0, 16'hFFFE, 26'h0000000, 32'hFC00_0000, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h2008_0005, 64'h0000_0000_0000_0000};
      repeat (2) tick();
      check("rst_pc", pc_out, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_req", imem_req, 0);
      check("rst_ir", ir_out, 0);
      check("rst_opcode", opcode, 0);
      check("rst_valid", ir_valid, 0);
      check("rst_err", fetch_err, 0);
      addr_q.push_back(64'h0);
      rst_n = 1'b1;
      tick();
      check("first_req", imem_req, 1);
      check("first_valid", ir_valid, 0);
      fetch(32'h2008_0005, 0);
      check("addi_opcode", opcode, 6'b001000);
      // Acks while in DECODE must not touch the instruction register.
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      repeat (2) tick();
      imem_ack = 1'b0;
      check("decode_ack_ir", ir_out, 32'h2008_0005);
      check("decode_ack_req", imem_req, 0);
      check("decode_ack_valid", ir_valid, 1);
      for (int i = 0; i < 11; i++) begin
         retire(vecs[i]);
         if (i == 1) begin
            PCen = 1'b1;
            jump = 1'b1;
            jump_idx = 26'h0000123;
            tick();
            PCen = 1'b0;
            jump = 1'b0;
            check("fetch_pcen_pc", pc_out, vecs[i].exp);
            check("fetch_pcen_req", imem_req, 1);
         end
         fetch(vecs[i].word, i == 3 ? 5 : i % 3);
      end
      tmp = '{1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 64'h4};
      retire(tmp);
      rst_n = 1'b0;
      #1;
      check("async_req", imem_req, 0);
      check("async_pc", pc_out, 0);
      check("async_valid", ir_valid, 0);
      tick();
      rst_n = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      addr_q.push_back(64'h0);
      tick();
      imem_ack = 1'b0;
      check("stray_valid", ir_valid, 0);
      check("stray_ir", ir_out, 0);
      check("stray_req", imem_req, 1);
      fetch(32'h8C01_0004, 1);
      check("lw_opcode", opcode, 6'h23);
      tmp = '{1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 64'h4};
      retire(tmp);
`ifdef IFETCH_TIMEOUT_EN
      repeat (3) tick();
      check("to_err_early", fetch_err, 0);
      check("to_req_early", imem_req, 1);
      tick();
      check("to_err", fetch_err, 1);
      check("to_req", imem_req, 0);
      imem_ack = 1'b1;
      repeat (3) tick();
      imem_ack = 1'b0;
      check("to_err_sticky", fetch_err, 1);
      check("to_valid", ir_valid, 0);
      check("to_req_low", imem_req, 0);
      rst_n = 1'b0;
      tick();
      check("to_err_clr", fetch_err, 0);
      rst_n = 1'b1;
      addr_q.push_back(64'h0);
      tick();
`else
      repeat (10) tick();
      check("wait_req", imem_req, 1);
      check("wait_err", fetch_err, 0);
      fetch(32'h0000_0000, 0);
`endif
      check("addr_q_empty", 64'(addr_q.size()), 0);
      check("ir_q_empty", 64'(ir_q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
